// File: rtl/perf_cnt_collector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : perf_cnt_collector_pkg                                             |
// | Brief  : Shared defaults, state encodings and constants for the collector. |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
package perf_cnt_collector_pkg;

  localparam int c_sum_wd_def  = 32;
  localparam int c_req_wd_def  = 10;
  localparam int c_scnt_wd_def = 16;

  // Wide enough for any supported SUM_WD; users slice down to their width.
  localparam logic [63:0] c_min_init = {64{1'b1}};

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_divide   = 3'd1;
  localparam logic [2:0] c_st_update   = 3'd2;
  localparam logic [2:0] c_st_ack      = 3'd3;
  localparam logic [2:0] c_st_wait_low = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = c_st_idle,
    ST_DIVIDE   = c_st_divide,
    ST_UPDATE   = c_st_update,
    ST_ACK      = c_st_ack,
    ST_WAIT_LOW = c_st_wait_low
  } state_t;

endpackage
`default_nettype wire

// File: rtl/perf_cnt_serial_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : perf_cnt_serial_div                                                |
// | Brief  : Restoring divider, one quotient bit per clock, fixed WD latency.   |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module perf_cnt_serial_div #(
  parameter int WD = 32
) (
  input  logic          i_bus_clk,
  input  logic          i_bus_rst_n,
  input  logic          i_start,
  input  logic [WD-1:0] i_dividend,
  input  logic [WD-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic [WD-1:0] o_quotient
);

  localparam int             c_cnt_wd = (WD > 1) ? $clog2(WD) : 1;
  localparam logic [c_cnt_wd-1:0] c_last = c_cnt_wd'(WD - 1);

  logic [WD-1:0]       r_rem;
  logic [WD-1:0]       r_quo;
  logic [WD-1:0]       r_div;
  logic [c_cnt_wd-1:0] r_cnt;
  logic                r_busy;

  logic [WD:0]         w_rem_shift;
  logic [WD:0]         w_diff;
  logic                w_ge;

  // The partial remainder is always below the divisor, so the WD+1 bit
  // difference never wraps and its top bit is a valid sign.
  assign w_rem_shift = {r_rem, r_quo[WD-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_div};
  assign w_ge        = ~w_diff[WD];

  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_ge ? w_diff[WD-1:0] : w_rem_shift[WD-1:0];
      r_quo  <= {r_quo[WD-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == c_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Done flags the cycle whose closing edge retires the last quotient bit.
  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == c_last);
  assign o_quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/perf_cnt_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : perf_cnt_collector                                                 |
// | Brief  : Captures a counter snapshot, averages it and keeps min/max stats.  |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module perf_cnt_collector
  import perf_cnt_collector_pkg::*;
#(
  parameter int SUM_WD  = c_sum_wd_def,
  parameter int REQ_WD  = c_req_wd_def,
  parameter int SCNT_WD = c_scnt_wd_def
) (
  input  logic               i_bus_clk,
  input  logic               i_bus_rst_n,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic               i_cnt_ready,
  input  logic [SUM_WD-1:0]  i_cnt_sum,
  input  logic [REQ_WD-1:0]  i_req_cnt,
  output logic               o_cp_cmplt,
  output logic [SUM_WD-1:0]  o_avg,
  output logic [SUM_WD-1:0]  o_max_avg,
  output logic [SUM_WD-1:0]  o_min_avg,
  output logic [SCNT_WD-1:0] o_sample_cnt,
  output logic               o_avg_valid,
  output logic               o_busy
);

  localparam logic [SUM_WD-1:0]  c_min_reset = c_min_init[SUM_WD-1:0];
  localparam logic [SCNT_WD-1:0] c_scnt_max  = {SCNT_WD{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_req_nz;
  logic                r_cp_cmplt;
  logic [SUM_WD-1:0]   r_avg;
  logic [SUM_WD-1:0]   r_max_avg;
  logic [SUM_WD-1:0]   r_min_avg;
  logic [SCNT_WD-1:0]  r_sample_cnt;
  logic                r_avg_valid;
  logic                r_busy;

  logic                w_capture;
  logic                w_cp_cmplt_nxt;
  logic [SUM_WD-1:0]   w_avg_nxt;
  logic [SUM_WD-1:0]   w_max_nxt;
  logic [SUM_WD-1:0]   w_min_nxt;
  logic [SCNT_WD-1:0]  w_scnt_nxt;
  logic                w_avg_valid_nxt;
  logic                w_busy_nxt;

  logic [SUM_WD-1:0]   w_divisor;
  logic                w_div_busy;
  logic                w_div_done;
  logic [SUM_WD-1:0]   w_quotient;

  assign w_capture = (r_state == ST_IDLE) && i_enable && i_cnt_ready;
  assign w_divisor = SUM_WD'(i_req_cnt);

  // The divider loads straight from the inputs on the capture edge, so it
  // holds its own copy of the snapshot for the whole division.
  perf_cnt_serial_div #(
    .WD (SUM_WD)
  ) u_div (
    .i_bus_clk   (i_bus_clk),
    .i_bus_rst_n (i_bus_rst_n),
    .i_start     (w_capture),
    .i_dividend  (i_cnt_sum),
    .i_divisor   (w_divisor),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_quotient)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cp_cmplt_nxt  = 1'b0;
    w_avg_valid_nxt = 1'b0;
    w_avg_nxt       = r_avg;
    w_max_nxt       = r_max_avg;
    w_min_nxt       = r_min_avg;
    w_scnt_nxt      = r_sample_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_nxt = (i_req_cnt != '0) ? ST_DIVIDE : ST_UPDATE;
        end
      end
      ST_DIVIDE: begin
        // Leaving on an idle divider keeps the FSM from ever stalling here.
        if (w_div_done || !w_div_busy) begin
          w_state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_state_nxt     = ST_ACK;
        w_avg_valid_nxt = 1'b1;
        if (r_req_nz) begin
          w_avg_nxt = w_quotient;
          w_max_nxt = (w_quotient > r_max_avg) ? w_quotient : r_max_avg;
          w_min_nxt = (w_quotient < r_min_avg) ? w_quotient : r_min_avg;
          if (r_sample_cnt != c_scnt_max) begin
            w_scnt_nxt = r_sample_cnt + 1'b1;
          end
        end else begin
          w_avg_nxt = '0;
        end
      end
      ST_ACK: begin
        w_state_nxt    = ST_WAIT_LOW;
        w_cp_cmplt_nxt = 1'b1;
      end
      ST_WAIT_LOW: begin
        // Holding here until ready drops stops a second copy of one snapshot.
        if (!i_cnt_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (i_clear) begin
      w_max_nxt  = '0;
      w_min_nxt  = c_min_reset;
      w_scnt_nxt = '0;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      r_req_nz     <= 1'b0;
      r_cp_cmplt   <= 1'b0;
      r_avg        <= '0;
      r_max_avg    <= '0;
      r_min_avg    <= c_min_reset;
      r_sample_cnt <= '0;
      r_avg_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_req_nz <= (i_req_cnt != '0);
      end
      r_cp_cmplt   <= w_cp_cmplt_nxt;
      r_avg        <= w_avg_nxt;
      r_max_avg    <= w_max_nxt;
      r_min_avg    <= w_min_nxt;
      r_sample_cnt <= w_scnt_nxt;
      r_avg_valid  <= w_avg_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign o_cp_cmplt   = r_cp_cmplt;
  assign o_avg        = r_avg;
  assign o_max_avg    = r_max_avg;
  assign o_min_avg    = r_min_avg;
  assign o_sample_cnt = r_sample_cnt;
  assign o_avg_valid  = r_avg_valid;
  assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_perf_cnt_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_perf_cnt_collector                                              |
// | Brief  : Directed scoreboard bench for the performance-counter collector.   |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_perf_cnt_collector;

  localparam int SUM_WD  = 32;
  localparam int REQ_WD  = 10;
  // Narrow sample counter so saturation is reachable in a short run.
  localparam int SCNT_WD = 4;
  localparam int c_scnt_max = (1 << SCNT_WD) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               clr;
  logic               rdy;
  logic [SUM_WD-1:0]  sum;
  logic [REQ_WD-1:0]  req;
  logic               o_cp_cmplt;
  logic [SUM_WD-1:0]  o_avg;
  logic [SUM_WD-1:0]  o_max_avg;
  logic [SUM_WD-1:0]  o_min_avg;
  logic [SCNT_WD-1:0] o_sample_cnt;
  logic               o_avg_valid;
  logic               o_busy;

  typedef struct {
    logic [SUM_WD-1:0]  avg;
    logic [SUM_WD-1:0]  mx;
    logic [SUM_WD-1:0]  mn;
    logic [SCNT_WD-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  logic [SUM_WD-1:0] m_max;
  logic [SUM_WD-1:0] m_min;
  int                m_cnt;

  perf_cnt_collector #(
    .SUM_WD  (SUM_WD),
    .REQ_WD  (REQ_WD),
    .SCNT_WD (SCNT_WD)
  ) dut (
    .i_bus_clk    (clk),
    .i_bus_rst_n  (rst_n),
    .i_enable     (en),
    .i_clear      (clr),
    .i_cnt_ready  (rdy),
    .i_cnt_sum    (sum),
    .i_req_cnt    (req),
    .o_cp_cmplt   (o_cp_cmplt),
    .o_avg        (o_avg),
    .o_max_avg    (o_max_avg),
    .o_min_avg    (o_min_avg),
    .o_sample_cnt (o_sample_cnt),
    .o_avg_valid  (o_avg_valid),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_max = '0;
    m_min = '1;
    m_cnt = 0;
  endtask

  task automatic push_expected(input logic [SUM_WD-1:0] s, input logic [REQ_WD-1:0] r,
                               input bit clr_hit);
    exp_t e;
    logic [SUM_WD-1:0] q;
    q = '0;
    if (r != '0) begin
      q = s / SUM_WD'(r);
      if (q > m_max) m_max = q;
      if (q < m_min) m_min = q;
      if (m_cnt < c_scnt_max) m_cnt++;
    end
    if (clr_hit) model_clear();
    e.avg = q;
    e.mx  = m_max;
    e.mn  = m_min;
    e.cnt = SCNT_WD'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avg"},   64'(o_avg),        64'h0);
    check({tag, "_max"},   64'(o_max_avg),    64'h0);
    check({tag, "_min"},   64'(o_min_avg),    64'hFFFF_FFFF);
    check({tag, "_cnt"},   64'(o_sample_cnt), 64'h0);
    check({tag, "_valid"}, 64'(o_avg_valid),  64'h0);
    check({tag, "_cp"},    64'(o_cp_cmplt),   64'h0);
    check({tag, "_busy"},  64'(o_busy),       64'h0);
  endtask

  // Called at a negedge with ready already driven high; the next posedge is
  // the capture edge, and latency counts posedges from there to the ack.
  task automatic wait_ack(input string tag, input int exp_lat);
    int lat;
    lat = -1;
    @(posedge clk);
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (o_cp_cmplt) begin
        lat = i;
        break;
      end
    end
    check({tag, "_ack_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    check({tag, "_ack_width"}, 64'(o_cp_cmplt), 64'h0);
  endtask

  task automatic release_ready(input string tag);
    rdy = 1'b0;
    @(negedge clk);
    check({tag, "_idle_after_ready_low"}, 64'(o_busy), 64'h0);
  endtask

  task automatic run_sample(input string tag, input logic [SUM_WD-1:0] s,
                            input logic [REQ_WD-1:0] r, input int hold);
    sum = s;
    req = r;
    rdy = 1'b1;
    push_expected(s, r, 1'b0);
    wait_ack(tag, (r != '0) ? SUM_WD + 2 : 2);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_held_in_wait_low"}, 64'(o_busy), 64'h1);
    end
    release_ready(tag);
  endtask

  // Scoreboard consumer: every avg_valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_avg_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("avg_valid_without_expectation", 64'(o_avg_valid), 64'h0);
        end else begin
          e = sb_q.pop_front();
          check("sb_avg", 64'(o_avg),        64'(e.avg));
          check("sb_max", 64'(o_max_avg),    64'(e.mx));
          check("sb_min", 64'(o_min_avg),    64'(e.mn));
          check("sb_cnt", 64'(o_sample_cnt), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    rdy   = 1'b0;
    sum   = '0;
    req   = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Enable low blocks capture even with ready high.
    rdy = 1'b1;
    repeat (4) @(negedge clk);
    check("disabled_no_capture", 64'(o_busy), 64'h0);
    rdy = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    run_sample("t1_1000_10", 32'd1000, 10'd10, 5);
    run_sample("t2_1500_3", 32'd1500, 10'd3, 0);
    run_sample("t3_zero_req", 32'd77, 10'd0, 0);

    // Inputs moving during the division must not disturb the captured snapshot.
    sum = 32'd300;
    req = 10'd3;
    rdy = 1'b1;
    push_expected(32'd300, 10'd3, 1'b0);
    fork
      wait_ack("t4_unstable_in", SUM_WD + 2);
      begin
        repeat (5) @(negedge clk);
        sum = 32'd9999;
        req = 10'd7;
      end
    join
    release_ready("t4_unstable_in");

    // Clear coincident with the UPDATE cycle discards the sample from stats.
    sum = 32'd40;
    req = 10'd4;
    rdy = 1'b1;
    push_expected(32'd40, 10'd4, 1'b1);
    @(posedge clk);
    repeat (SUM_WD) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5_cnt_after_clear", 64'(o_sample_cnt), 64'h0);
    @(negedge clk);
    check("t5_ack", 64'(o_cp_cmplt), 64'h1);
    release_ready("t5_clear_update");

    run_sample("t6_pre", 32'd600, 10'd2, 0);

    // Reset in the middle of a division: no ack, then fresh capture.
    sum = 32'd800;
    req = 10'd8;
    rdy = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_mid_reset");
    sb_q.delete();
    model_clear();
    repeat (3) @(negedge clk);
    check("t6_no_ack_in_reset", 64'(o_cp_cmplt), 64'h0);
    rst_n = 1'b1;
    push_expected(32'd800, 10'd8, 1'b0);
    wait_ack("t6_recapture", SUM_WD + 2);
    release_ready("t6_recapture");

    // Saturation of the sample counter.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check("t7_cleared_cnt", 64'(o_sample_cnt), 64'h0);
    for (int i = 0; i < c_scnt_max + 2; i++) begin
      run_sample("t7_sat", SUM_WD'(i * 37 + 11), REQ_WD'((i % 5) + 1), 0);
    end
    check("t7_cnt_saturated", 64'(o_sample_cnt), 64'(c_scnt_max));

    run_sample("t8_full_range", 32'hFFFF_FFFF, 10'd1, 0);
    check("t8_avg", 64'(o_avg), 64'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
